// File: rtl/alu_pkg.sv
// Shared constants and pipeline entry type for the ALU issue/writeback stage.
// Entry fields are sized for the widest supported configuration; users cast to their widths.
package alu_pkg;

   localparam logic [2:0] ALU_ID0  = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_EQ   = 3'd3;
   localparam logic [2:0] ALU_LE   = 3'd4;
   localparam logic [2:0] ALU_GE   = 3'd5;
   localparam logic [2:0] ALU_ID1  = 3'd6;
   localparam logic [2:0] ALU_ZERO = 3'd7;

   typedef enum logic [1:0] {
      KIND_REG    = 2'd0,
      KIND_JUMP   = 2'd1,
      KIND_RESULT = 2'd2,
      KIND_NOP    = 2'd3
   } kind_e;

   localparam int unsigned ENTRY_DEST_WIDTH   = 8;
   localparam int unsigned ENTRY_TARGET_WIDTH = 32;

   typedef struct packed {
      logic                          valid;
      kind_e                         kind;
      logic [ENTRY_DEST_WIDTH-1:0]   dest;
      logic [ENTRY_TARGET_WIDTH-1:0] jump_addr;
   } pipe_entry_t;

endpackage

// File: rtl/alu_issue_wb_if.sv
// Decoder-to-issue handshake bundle: the decoder is master, the issue stage is slave.
interface alu_issue_wb_if #(
   parameter int unsigned REG_ADDR_WIDTH   = 4,
   parameter int unsigned INSTR_ADDR_WIDTH = 16
);
   logic                        issue_valid;
   logic                        issue_ready;
   logic [2:0]                  issue_op;
   logic [1:0]                  issue_kind;
   logic [REG_ADDR_WIDTH-1:0]   issue_dest;
   logic [REG_ADDR_WIDTH-1:0]   issue_src0_addr;
   logic [REG_ADDR_WIDTH-1:0]   issue_src1_addr;
   logic                        issue_src0_used;
   logic                        issue_src1_used;
   logic [INSTR_ADDR_WIDTH-1:0] issue_jump_addr;

   modport master (
      output issue_valid, issue_op, issue_kind, issue_dest,
             issue_src0_addr, issue_src1_addr, issue_src0_used, issue_src1_used,
             issue_jump_addr,
      input  issue_ready
   );

   modport slave (
      input  issue_valid, issue_op, issue_kind, issue_dest,
             issue_src0_addr, issue_src1_addr, issue_src0_used, issue_src1_used,
             issue_jump_addr,
      output issue_ready
   );
endinterface

// File: rtl/reg_scoreboard.sv
// One busy bit per architectural register, with set/clear update and three read ports.
module reg_scoreboard #(
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set_en,
   input  logic [ADDR_WIDTH-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [ADDR_WIDTH-1:0] clr_addr,
   input  logic [ADDR_WIDTH-1:0] look0_addr,
   input  logic [ADDR_WIDTH-1:0] look1_addr,
   input  logic [ADDR_WIDTH-1:0] look2_addr,
   output logic                  look0_busy,
   output logic                  look1_busy,
   output logic                  look2_busy
);
   logic [2**ADDR_WIDTH-1:0] busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
      end else begin
         if (clr_en) busy[clr_addr] <= 1'b0;
         if (set_en) busy[set_addr] <= 1'b1;
      end
   end

   assign look0_busy = busy[look0_addr];
   assign look1_busy = busy[look1_addr];
   assign look2_busy = busy[look2_addr];
endmodule

// File: rtl/alu_issue_wb.sv
// Issue/writeback control around the multi-cycle ALU: hazard stall, op delay, and
// retirement of the ALU result as register write, conditional jump, or result strobe.
module alu_issue_wb
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned REG_ADDR_WIDTH   = 4,
   parameter int unsigned INSTR_ADDR_WIDTH = 16,
   parameter int unsigned ALU_LATENCY      = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   alu_issue_wb_if.slave               issue,
   output logic [2:0]                  alu_ctrl,
   input  logic [DATA_WIDTH-1:0]       alu_out,
   output logic                        reg_we,
   output logic [REG_ADDR_WIDTH-1:0]   reg_waddr,
   output logic [DATA_WIDTH-1:0]       reg_wdata,
   output logic                        jump_en,
   output logic [INSTR_ADDR_WIDTH-1:0] jump_addr,
   output logic                        result_valid,
   output logic [DATA_WIDTH-1:0]       result_data,
   output logic                        jump_pending
);
   pipe_entry_t               pipe [ALU_LATENCY];
   pipe_entry_t               incoming;
   pipe_entry_t               last;
   logic [2:0]                op_q [ALU_LATENCY-1];
   kind_e                     kind_in;
   logic                      accept;
   logic                      busy_src0, busy_src1, busy_dest;
   logic                      retire_reg;
   logic [REG_ADDR_WIDTH-1:0] retire_dest;

   assign kind_in     = kind_e'(issue.issue_kind);
   assign last        = pipe[ALU_LATENCY-1];
   assign retire_dest = REG_ADDR_WIDTH'(last.dest);
   assign retire_reg  = last.valid && (last.kind == KIND_REG);

   // A jump anywhere in flight blocks issue, so nothing younger ever needs squashing.
   always_comb begin
      jump_pending = 1'b0;
      for (int unsigned i = 0; i < ALU_LATENCY; i++)
         if (pipe[i].valid && pipe[i].kind == KIND_JUMP) jump_pending = 1'b1;
   end

   assign issue.issue_ready = ~jump_pending
                            & ~(issue.issue_src0_used & busy_src0)
                            & ~(issue.issue_src1_used & busy_src1)
                            & ~((kind_in == KIND_REG) & busy_dest);
   assign accept = issue.issue_valid & issue.issue_ready;

   always_comb begin
      incoming           = '0;
      incoming.valid     = 1'b1;
      incoming.kind      = kind_in;
      incoming.dest      = ENTRY_DEST_WIDTH'(issue.issue_dest);
      incoming.jump_addr = ENTRY_TARGET_WIDTH'(issue.issue_jump_addr);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < ALU_LATENCY; i++)   pipe[i] <= '0;
         for (int unsigned i = 0; i < ALU_LATENCY-1; i++) op_q[i] <= '0;
      end else begin
         pipe[0] <= accept ? incoming : '0;
         for (int unsigned i = 1; i < ALU_LATENCY; i++)   pipe[i] <= pipe[i-1];
         op_q[0] <= issue.issue_op;
         for (int unsigned i = 1; i < ALU_LATENCY-1; i++) op_q[i] <= op_q[i-1];
      end
   end

   assign alu_ctrl = op_q[ALU_LATENCY-2];

   always_comb begin
      reg_we       = 1'b0;
      reg_waddr    = '0;
      reg_wdata    = '0;
      jump_en      = 1'b0;
      jump_addr    = '0;
      result_valid = 1'b0;
      result_data  = '0;
      if (last.valid) begin
         case (last.kind)
            KIND_REG: begin
               reg_we    = 1'b1;
               reg_waddr = retire_dest;
               reg_wdata = alu_out;
            end
            KIND_JUMP: begin
               jump_en   = alu_out[0];
               jump_addr = INSTR_ADDR_WIDTH'(last.jump_addr);
            end
            KIND_RESULT: begin
               result_valid = 1'b1;
               result_data  = alu_out;
            end
            default: ;
         endcase
      end
   end

   reg_scoreboard #(.ADDR_WIDTH(REG_ADDR_WIDTH)) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .set_en     (accept && (kind_in == KIND_REG)),
      .set_addr   (issue.issue_dest),
      .clr_en     (retire_reg),
      .clr_addr   (retire_dest),
      .look0_addr (issue.issue_src0_addr),
      .look1_addr (issue.issue_src1_addr),
      .look2_addr (issue.issue_dest),
      .look0_busy (busy_src0),
      .look1_busy (busy_src1),
      .look2_busy (busy_dest)
   );
endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb: expected retirements are queued at accept and
// checked by a monitor in the retire cycle; the bench also plays the ALU.
module tb_alu_issue_wb;
   import alu_pkg::*;

   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 4;
   localparam int unsigned IW  = 16;
   localparam int          LAT = 2;
   localparam int          MAX_WAIT = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    alu_ctrl;
   logic [DW-1:0] alu_out;
   logic          reg_we;
   logic [AW-1:0] reg_waddr;
   logic [DW-1:0] reg_wdata;
   logic          jump_en;
   logic [IW-1:0] jump_addr;
   logic          result_valid;
   logic [DW-1:0] result_data;
   logic          jump_pending;

   alu_issue_wb_if #(.REG_ADDR_WIDTH(AW), .INSTR_ADDR_WIDTH(IW)) bus ();

   alu_issue_wb #(
      .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .INSTR_ADDR_WIDTH(IW), .ALU_LATENCY(LAT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .issue        (bus),
      .alu_ctrl     (alu_ctrl),
      .alu_out      (alu_out),
      .reg_we       (reg_we),
      .reg_waddr    (reg_waddr),
      .reg_wdata    (reg_wdata),
      .jump_en      (jump_en),
      .jump_addr    (jump_addr),
      .result_valid (result_valid),
      .result_data  (result_data),
      .jump_pending (jump_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            due;
      kind_e         kind;
      logic [AW-1:0] dest;
      logic [IW-1:0] tgt;
      logic [DW-1:0] aluv;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;
   int   w;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // ALU stand-in: the queued result appears exactly in its retire cycle, junk otherwise.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) alu_out = exp_q[0].aluv;
      else alu_out = $urandom;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            case (e.kind)
               KIND_REG: begin
                  check("reg_strobes", {reg_we, jump_en, result_valid}, 3'b100);
                  check("reg_waddr", reg_waddr, e.dest);
                  check("reg_wdata", reg_wdata, e.aluv);
               end
               KIND_JUMP: begin
                  check("jump_strobes", {reg_we, jump_en, result_valid}, {1'b0, e.aluv[0], 1'b0});
                  check("jump_addr", jump_addr, e.tgt);
               end
               KIND_RESULT: begin
                  check("result_strobes", {reg_we, jump_en, result_valid}, 3'b001);
                  check("result_data", result_data, e.aluv);
               end
               default: check("nop_strobes", {reg_we, jump_en, result_valid}, 3'b000);
            endcase
         end else begin
            check("idle_strobes", {reg_we, jump_en, result_valid}, 3'b000);
            check("idle_data", |{reg_waddr, reg_wdata, jump_addr, result_data}, 1'b0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_issue(input logic [2:0] op, input kind_e kind, input logic [AW-1:0] dest,
                           input logic [AW-1:0] s0, input logic s0u,
                           input logic [AW-1:0] s1, input logic s1u,
                           input logic [IW-1:0] tgt, input logic [DW-1:0] aluv,
                           output int waited);
      bit accepted = 1'b0;
      waited = 0;
      bus.issue_op        = op;
      bus.issue_kind      = kind;
      bus.issue_dest      = dest;
      bus.issue_src0_addr = s0;
      bus.issue_src0_used = s0u;
      bus.issue_src1_addr = s1;
      bus.issue_src1_used = s1u;
      bus.issue_jump_addr = tgt;
      bus.issue_valid     = 1'b1;
      while (!accepted && waited <= MAX_WAIT) begin
         @(negedge clk);
         if (bus.issue_ready) begin
            exp_q.push_back('{cyc + LAT, kind, dest, tgt, aluv});
            accepted = 1'b1;
         end else begin
            waited++;
         end
         @(posedge clk);
         #1;
      end
      bus.issue_valid = 1'b0;
      check("issue_accepted", accepted, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset               = 1'b1;
      bus.issue_valid     = 1'b0;
      bus.issue_op        = '0;
      bus.issue_kind      = '0;
      bus.issue_dest      = '0;
      bus.issue_src0_addr = '0;
      bus.issue_src1_addr = '0;
      bus.issue_src0_used = 1'b0;
      bus.issue_src1_used = 1'b0;
      bus.issue_jump_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      check("reset_ready", bus.issue_ready, 1'b1);
      check("reset_jump_pending", jump_pending, 1'b0);
      check("reset_alu_ctrl", alu_ctrl, 3'd0);
      idle(1);

      // single add into r3
      do_issue(ALU_ADD, KIND_REG, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0, 32'd7, w);
      check("add_wait", w, 0);
      @(negedge clk);
      check("add_alu_ctrl", alu_ctrl, ALU_ADD);
      idle(3);

      // RAW on r5 through src0
      do_issue(ALU_SUB, KIND_REG, 4'd5, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0, 32'h55, w);
      do_issue(ALU_ID0, KIND_RESULT, 4'd0, 4'd5, 1'b1, 4'd0, 1'b0, 16'h0, 32'hA5A5, w);
      check("raw_src0_wait", w, 2);
      idle(3);

      // src1 hazard only counts when the operand is used
      do_issue(ALU_ADD, KIND_REG, 4'd7, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0, 32'h77, w);
      do_issue(ALU_ID1, KIND_RESULT, 4'd0, 4'd0, 1'b0, 4'd7, 1'b0, 16'h0, 32'h1357, w);
      check("src1_unused_wait", w, 0);
      do_issue(ALU_LE, KIND_RESULT, 4'd0, 4'd0, 1'b0, 4'd7, 1'b1, 16'h0, 32'h2468, w);
      check("src1_used_wait", w, 1);
      idle(4);

      // taken jump
      do_issue(ALU_EQ, KIND_JUMP, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0040, 32'd1, w);
      @(negedge clk);
      check("jump_pending_t1", jump_pending, 1'b1);
      check("jump_ready_t1", bus.issue_ready, 1'b0);
      @(negedge clk);
      check("jump_pending_t2", jump_pending, 1'b1);
      @(negedge clk);
      check("jump_pending_t3", jump_pending, 1'b0);
      check("jump_ready_t3", bus.issue_ready, 1'b1);
      idle(2);

      // not-taken jump (only bit 0 decides), then an independent op stalls behind it
      do_issue(ALU_EQ, KIND_JUMP, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 16'hBEEE, 32'hFFFF_FFFE, w);
      do_issue(ALU_ID0, KIND_RESULT, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0, 32'h1234, w);
      check("jump_stall_wait", w, 2);
      idle(4);

      // back-to-back independent reg write and result strobe
      do_issue(ALU_ADD, KIND_REG, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0, 32'h1111, w);
      do_issue(ALU_SUB, KIND_RESULT, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0, 32'hABCD, w);
      check("b2b_wait", w, 0);
      @(negedge clk);
      check("b2b_alu_ctrl", alu_ctrl, ALU_SUB);
      idle(3);

      // nop retires without any strobe
      do_issue(ALU_ZERO, KIND_NOP, 4'd9, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0, 32'hDEAD, w);
      check("nop_wait", w, 0);
      idle(4);

      // reset while a write to r2 is in flight
      do_issue(ALU_GE, KIND_REG, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0, 32'h22, w);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.issue_kind      = KIND_REG;
      bus.issue_dest      = 4'd2;
      bus.issue_src0_addr = 4'd2;
      bus.issue_src0_used = 1'b1;
      @(negedge clk);
      check("post_reset_ready", bus.issue_ready, 1'b1);
      check("post_reset_alu_ctrl", alu_ctrl, 3'd0);
      check("post_reset_jump_pending", jump_pending, 1'b0);
      idle(2);

      // WAW on r4
      do_issue(ALU_ADD, KIND_REG, 4'd4, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0, 32'h44, w);
      do_issue(ALU_SUB, KIND_REG, 4'd4, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0, 32'h4444, w);
      check("waw_wait", w, 2);
      idle(5);

      check("scoreboard_drained", exp_q.size(), 0);
      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
